// File: rtl/stopwatch_ctrl.sv
// Control sequencer for the mm:ss stopwatch: input sync/debounce, RUN/PAUSE/ADJUST FSM,
// tick and blink dividers. Optional auto-increment in ADJUST: STOPWATCH_ADJ_AUTOINC_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int DB_CYCLES = 1000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk_c,
  input  logic       reset_c,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       adj_sw,
  input  logic [1:0] sel_sw,
  input  logic [3:0] num_sw,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       ld_en,
  output logic [1:0] ld_sel,
  output logic [3:0] ld_val,
  output logic       paused,
  output logic       adj_active,
`ifdef STOPWATCH_ADJ_AUTOINC_EN
  output logic       adj_inc,
`endif
  output logic [3:0] an_mask
);

  typedef enum logic [1:0] {ST_RUN, ST_PAUSE, ST_ADJUST} state_t;

  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

  // Switch synchronisers: {adj, sel[1:0], num[3:0]}
  logic [6:0] sw_s1, sw_s2;
  logic       adj_s;
  logic [1:0] sel_s;
  logic [3:0] num_s;

  // Button path, index 0 = pause, 1 = clear
  logic [1:0]    btn_s1, btn_s2;
  logic [1:0]    db_level, db_level_q, db_press;
  logic [DW-1:0] db_cnt [2];
  logic          pause_press, clr_press, pause_go, load_go;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink;

  assign adj_s       = sw_s2[6];
  assign sel_s       = sw_s2[5:4];
  assign num_s       = sw_s2[3:0];
  assign pause_press = db_press[0];
  assign clr_press   = db_press[1];
  // Clear wins over a simultaneous pause press.
  assign pause_go    = pause_press & ~clr_press;
  assign load_go     = (state == ST_ADJUST) & adj_s & pause_go;

  function automatic logic [3:0] clamp_digit(input logic [1:0] sel, input logic [3:0] v);
    logic [3:0] lim;
    lim = sel[0] ? 4'd5 : 4'd9;
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [3:0] digit_blank(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

  // Sync + debounce: level moves after DB_CYCLES disagreeing cycles, press follows one cycle later.
  always_ff @(posedge clk_c) begin
    if (!reset_c) begin
      // NOTE: synchroniser and debounce flops are reset too, so a reset discards any pending press.
      sw_s1      <= '0;
      sw_s2      <= '0;
      btn_s1     <= '0;
      btn_s2     <= '0;
      db_level   <= '0;
      db_level_q <= '0;
      db_press   <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sw_s1      <= {adj_sw, sel_sw, num_sw};
      sw_s2      <= sw_s1;
      btn_s1     <= {btn_clr, btn_pause};
      btn_s2     <= btn_s1;
      db_level_q <= db_level;
      db_press   <= db_level & ~db_level_q;
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= btn_s2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_RUN:    if (adj_s) state_nxt = ST_ADJUST; else if (pause_go) state_nxt = ST_PAUSE;
      ST_PAUSE:  if (adj_s) state_nxt = ST_ADJUST; else if (pause_go) state_nxt = ST_RUN;
      ST_ADJUST: if (!adj_s) state_nxt = ST_PAUSE;
      default:   state_nxt = ST_RUN;
    endcase
  end

`ifdef STOPWATCH_ADJ_AUTOINC_EN
  localparam int HW = $clog2(2 * BLINK_DIV + 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(2 * BLINK_DIV - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(BLINK_DIV);
  logic [HW-1:0] hold_cnt;
`endif

  always_ff @(posedge clk_c) begin
    if (!reset_c) begin
      state      <= ST_RUN;
      tick_cnt   <= '0;
      blink_cnt  <= '0;
      blink      <= 1'b0;
      cnt_en     <= 1'b0;
      cnt_clr    <= 1'b0;
      ld_en      <= 1'b0;
      ld_sel     <= '0;
      ld_val     <= '0;
      paused     <= 1'b0;
      adj_active <= 1'b0;
      an_mask    <= 4'b1111;
`ifdef STOPWATCH_ADJ_AUTOINC_EN
      adj_inc    <= 1'b0;
      hold_cnt   <= '0;
`endif
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block override earlier defaults.
      state      <= state_nxt;
      paused     <= (state_nxt != ST_RUN);
      adj_active <= (state_nxt == ST_ADJUST);
      cnt_en     <= 1'b0;
      cnt_clr    <= clr_press;
      ld_en      <= 1'b0;

      // Tick only while staying in RUN; PAUSE holds the partial second.
      if (clr_press) begin
        tick_cnt <= '0;
      end else if (state == ST_RUN && state_nxt == ST_RUN) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
          cnt_en   <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end else if (state_nxt == ST_ADJUST && state != ST_ADJUST) begin
        tick_cnt <= '0;
      end

      if (load_go) begin
        ld_en  <= 1'b1;
        ld_sel <= sel_s;
        ld_val <= clamp_digit(sel_s, num_s);
      end

      // an_mask tracks the blink value being written this cycle.
      if (state == ST_ADJUST && state_nxt == ST_ADJUST) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink     <= ~blink;
          an_mask   <= blink ? 4'b1111 : digit_blank(sel_s);
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
          an_mask   <= blink ? digit_blank(sel_s) : 4'b1111;
        end
      end else begin
        blink_cnt <= '0;
        blink     <= 1'b0;
        an_mask   <= 4'b1111;
      end

`ifdef STOPWATCH_ADJ_AUTOINC_EN
      adj_inc <= 1'b0;
      if (state == ST_ADJUST && state_nxt == ST_ADJUST && db_level[0]) begin
        if (hold_cnt == HOLD_LAST) begin
          adj_inc  <= 1'b1;
          ld_sel   <= sel_s;
          hold_cnt <= HOLD_RELOAD;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DB_CYCLES=4, BLINK_DIV=3.
// Cycle k = the k-th rising edge after reset release; outputs sampled 1 ns after that edge.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int DB_CYCLES = 4;
  localparam int BLINK_DIV = 3;

  logic       clk_c = 1'b0;
  logic       reset_c = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_clr = 1'b0;
  logic       adj_sw = 1'b0;
  logic [1:0] sel_sw = '0;
  logic [3:0] num_sw = '0;
  logic       cnt_en, cnt_clr, ld_en, paused, adj_active;
  logic [1:0] ld_sel;
  logic [3:0] ld_val, an_mask;
`ifdef STOPWATCH_ADJ_AUTOINC_EN
  logic       adj_inc;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES), .BLINK_DIV(BLINK_DIV)) dut (
    .clk_c     (clk_c),
    .reset_c   (reset_c),
    .btn_pause (btn_pause),
    .btn_clr   (btn_clr),
    .adj_sw    (adj_sw),
    .sel_sw    (sel_sw),
    .num_sw    (num_sw),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .ld_val    (ld_val),
    .paused    (paused),
    .adj_active(adj_active),
`ifdef STOPWATCH_ADJ_AUTOINC_EN
    .adj_inc   (adj_inc),
`endif
    .an_mask   (an_mask)
  );

  always #5 clk_c = ~clk_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk_c);
    #1;
  endtask

  task automatic do_reset();
    reset_c   = 1'b0;
    btn_pause = 1'b0;
    btn_clr   = 1'b0;
    adj_sw    = 1'b0;
    sel_sw    = '0;
    num_sw    = '0;
    repeat (3) cyc();
    reset_c = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cnt_en"},     32'(cnt_en),     32'd0);
    check({tag, " cnt_clr"},    32'(cnt_clr),    32'd0);
    check({tag, " ld_en"},      32'(ld_en),      32'd0);
    check({tag, " ld_sel"},     32'(ld_sel),     32'd0);
    check({tag, " ld_val"},     32'(ld_val),     32'd0);
    check({tag, " paused"},     32'(paused),     32'd0);
    check({tag, " adj_active"}, 32'(adj_active), 32'd0);
    check({tag, " an_mask"},    32'(an_mask),    32'hF);
  endtask

  initial begin
    // Reset values, then free-running ticks on cycles 10, 20, 30
    do_reset();
    check_reset_outputs("rst");
    for (int k = 1; k <= 35; k++) begin
      cyc();
      check($sformatf("t1 cnt_en k=%0d", k), 32'(cnt_en), 32'(k % 10 == 0));
      check($sformatf("t1 paused k=%0d", k), 32'(paused), 32'd0);
    end

    // Pause press (press at 7, paused at 8, tick held at 7); resume press at 37, cnt_en at 41
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      btn_pause = (k <= 20) || (k >= 31);
      cyc();
      check($sformatf("t2 press k=%0d", k),  32'(dut.pause_press), 32'(k == 7 || k == 37));
      check($sformatf("t2 paused k=%0d", k), 32'(paused), 32'(k >= 8 && k <= 37));
      check($sformatf("t2 cnt_en k=%0d", k), 32'(cnt_en), 32'(k == 41));
    end

    // Bouncing pause input, 2-cycle runs: never accepted
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      btn_pause = (k <= 30) && (((k - 1) / 2) % 2 == 0);
      cyc();
      check($sformatf("t3 press k=%0d", k),  32'(dut.pause_press), 32'd0);
      check($sformatf("t3 paused k=%0d", k), 32'(paused), 32'd0);
    end

    // ADJUST loads with clamping: sel 01/num 8 -> 5 at k=13, sel 10/num 12 -> 9 at k=33
    do_reset();
    adj_sw = 1'b1;
    sel_sw = 2'b01;
    num_sw = 4'd8;
    for (int k = 1; k <= 35; k++) begin
      if (k == 22) begin
        sel_sw = 2'b10;
        num_sw = 4'd12;
      end
      btn_pause = (k >= 6 && k <= 15) || (k >= 26);
      cyc();
      check($sformatf("t4 ld_en k=%0d", k),      32'(ld_en), 32'(k == 13 || k == 33));
      check($sformatf("t4 cnt_en k=%0d", k),     32'(cnt_en), 32'd0);
      check($sformatf("t4 adj_active k=%0d", k), 32'(adj_active), 32'(k >= 3));
      if (k == 13) begin
        check("t4 ld_sel first", 32'(ld_sel), 32'd1);
        check("t4 ld_val first", 32'(ld_val), 32'd5);
      end
      if (k == 20) check("t4 ld_val held", 32'(ld_val), 32'd5);
      if (k == 33) begin
        check("t4 ld_sel second", 32'(ld_sel), 32'd2);
        check("t4 ld_val second", 32'(ld_val), 32'd9);
      end
    end

    // Blink on sec-ones digit, then leave ADJUST into PAUSE at k=17
    do_reset();
    adj_sw = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      if (k == 15) adj_sw = 1'b0;
      cyc();
      check($sformatf("t5 an_mask k=%0d", k), 32'(an_mask),
            (k >= 6 && k <= 16 && ((k - 6) / 3) % 2 == 0) ? 32'hE : 32'hF);
      check($sformatf("t5 adj_active k=%0d", k), 32'(adj_active), 32'(k >= 3 && k <= 16));
      check($sformatf("t5 paused k=%0d", k),     32'(paused), 32'(k >= 3));
    end

    // Clear and pause together: clear at k=8, pause dropped, next tick at k=18
    do_reset();
    btn_pause = 1'b1;
    btn_clr   = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      if (k == 11) begin
        btn_pause = 1'b0;
        btn_clr   = 1'b0;
      end
      if (k == 20) adj_sw = 1'b1;
      cyc();
      check($sformatf("t6 cnt_clr k=%0d", k), 32'(cnt_clr), 32'(k == 8));
      check($sformatf("t6 cnt_en k=%0d", k),  32'(cnt_en), 32'(k == 18));
      check($sformatf("t6 paused k=%0d", k),  32'(paused), 32'(k >= 22));
    end
    check("t6 pre-reset an_mask",    32'(an_mask), 32'hE);
    check("t6 pre-reset adj_active", 32'(adj_active), 32'd1);

    // Reset mid-operation: outputs back to reset values after one edge
    reset_c = 1'b0;
    adj_sw  = 1'b0;
    cyc();
    check_reset_outputs("t6 mid-reset");
    reset_c = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("t6 post cnt_en k=%0d", k), 32'(cnt_en), 32'(k == 10));
      check($sformatf("t6 post paused k=%0d", k), 32'(paused), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
